// File: rtl/stack_cpu_core_pkg.sv
// Shared encodings for the stack CPU: instruction classes, ALU ops,
// jump conditions, SYS sub-ops and the core FSM state.
package stack_cpu_core_pkg;

    typedef enum logic [1:0] {
        CLS_PUSH = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_JUMP = 2'b10,
        CLS_SYS  = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_ADC = 3'd6,
        ALU_SHL = 3'd7
    } alu_op_e;

    // Codes 5..7 are "never taken" and fall into the default arm.
    typedef enum logic [2:0] {
        JC_ALWAYS = 3'd0,
        JC_ZERO   = 3'd1,
        JC_NZERO  = 3'd2,
        JC_CARRY  = 3'd3,
        JC_NEG    = 3'd4
    } jcond_e;

    typedef enum logic [1:0] {
        SYS_NOP  = 2'd0,
        SYS_POP  = 2'd1,
        SYS_DUP  = 2'd2,
        SYS_HALT = 2'd3
    } sys_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/stack_cpu_core_if.sv
// Instruction-fetch handshake between the core (master) and instruction memory (slave).
interface stack_cpu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] o_imemAddr;
    logic              o_imemReq;
    logic              i_imemAck;
    logic [DATA_W+1:0] i_instr;

    modport master (output o_imemAddr, o_imemReq, input i_imemAck, i_instr);
    modport slave  (input o_imemAddr, o_imemReq, output i_imemAck, i_instr);
endinterface

// File: rtl/stack_cpu_core_data_stack.sv
// Data stack: storage, depth counter and overflow/underflow detection.
// An operation states how many operands it needs (need_i), how many it
// removes (pop_i) and whether it pushes; an erroneous op commits nothing.
module data_stack import stack_cpu_core_pkg::*; #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 16,
    localparam int PW         = $clog2(STACK_DEPTH),
    localparam int DPW        = PW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        need_i,
    input  logic [1:0]        pop_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] top_o,
    output logic [DATA_W-1:0] nos_o,
    output logic [DPW-1:0]    depth_o,
    output logic              err_o
);
    logic [DATA_W-1:0] mem_q [STACK_DEPTH];
    logic [DPW-1:0]    depth_q, depth_d;
    logic [DPW-1:0]    after_pop, top_pos, nos_pos;
    logic              underflow, overflow;

    assign top_pos = depth_q - DPW'(1);
    assign nos_pos = depth_q - DPW'(2);
    assign top_o   = (depth_q != '0) ? mem_q[top_pos[PW-1:0]] : '0;
    assign nos_o   = (depth_q > DPW'(1)) ? mem_q[nos_pos[PW-1:0]] : '0;
    assign depth_o = depth_q;

    // Error detection and next depth; the push lands at index after_pop.
    always_comb begin
        underflow = depth_q < DPW'(need_i);
        after_pop = depth_q - DPW'(pop_i);
        overflow  = push_i && (after_pop == DPW'(STACK_DEPTH));
        err_o     = en_i && (underflow || overflow);
        depth_d   = depth_q;
        if (en_i && !err_o)
            depth_d = after_pop + DPW'(push_i);
    end

    // Depth counter, the only stack state cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) depth_q <= '0;
        else       depth_q <= depth_d;
    end

    // Storage write; contents are left uninitialised by reset.
    always_ff @(posedge clk_i) begin
        if (en_i && !err_o && push_i)
            mem_q[after_pop[PW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/stack_cpu_core.sv
// Stack CPU core: FETCH/EXEC/HALT/FAULT sequencer, ALU, jump unit and IP.
module stack_cpu_core import stack_cpu_core_pkg::*; #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    stack_cpu_core_if.master               imem,
    output logic [DATA_W-1:0]              o_top,
    output logic [$clog2(STACK_DEPTH):0]   o_depth,
    output logic                           o_carry,
    output logic                           o_halted,
    output logic                           o_fault
);
    // Jump target sits below the 3-bit condition field, so it can never
    // be wider than DATA_W-3 bits; narrower targets are zero-extended.
    localparam int TGT_W = (ADDR_W < DATA_W - 3) ? ADDR_W : DATA_W - 3;

    state_e            state_q;
    logic [ADDR_W-1:0] ip_q, ip_d;
    logic [DATA_W+1:0] instr_q;
    logic              carry_q, carry_d;
    logic              req_q, halted_q, fault_q;

    logic [DATA_W-1:0] payload, top, nos, wdata, res;
    logic [DATA_W:0]   sum, diff, adc;
    logic [ADDR_W-1:0] target;
    logic [1:0]        need, pop;
    logic              push, halt, take, st_en, st_err;

    assign payload = instr_q[DATA_W-1:0];
    assign target  = ADDR_W'(payload[TGT_W-1:0]);
    assign sum     = {1'b0, nos} + {1'b0, top};
    assign diff    = {1'b0, nos} - {1'b0, top};
    assign adc     = sum + (DATA_W+1)'(carry_q);
    assign st_en   = (state_q == ST_EXEC);

    data_stack #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .en_i    (st_en),
        .need_i  (need),
        .pop_i   (pop),
        .push_i  (push),
        .wdata_i (wdata),
        .top_o   (top),
        .nos_o   (nos),
        .depth_o (o_depth),
        .err_o   (st_err)
    );

    // Decode the latched instruction into a stack op, ALU result, carry and next IP.
    always_comb begin
        need    = 2'd0;
        pop     = 2'd0;
        push    = 1'b0;
        wdata   = '0;
        res     = '0;
        halt    = 1'b0;
        take    = 1'b0;
        carry_d = carry_q;
        ip_d    = ip_q + ADDR_W'(1);
        case (instr_q[DATA_W+1:DATA_W])
            CLS_PUSH: begin
                push  = 1'b1;
                wdata = payload;
            end
            CLS_ALU: begin
                need = (payload[2:0] == ALU_NOT) ? 2'd1 : 2'd2;
                pop  = need;
                push = 1'b1;
                case (payload[2:0])
                    ALU_ADD: begin res = sum[DATA_W-1:0];  carry_d = sum[DATA_W];   end
                    ALU_SUB: begin res = diff[DATA_W-1:0]; carry_d = ~diff[DATA_W]; end
                    ALU_AND: res = nos & top;
                    ALU_OR:  res = nos | top;
                    ALU_XOR: res = nos ^ top;
                    ALU_NOT: res = ~top;
                    ALU_ADC: begin res = adc[DATA_W-1:0];  carry_d = adc[DATA_W];   end
                    default: begin res = top << 1;         carry_d = top[DATA_W-1]; end
                endcase
                wdata = res;
            end
            CLS_JUMP: begin
                case (payload[DATA_W-1:DATA_W-3])
                    JC_ALWAYS: take = 1'b1;
                    JC_ZERO:   take = (top == '0);
                    JC_NZERO:  take = (top != '0);
                    JC_CARRY:  take = carry_q;
                    JC_NEG:    take = top[DATA_W-1];
                    default:   take = 1'b0;
                endcase
                if (take) ip_d = target;
            end
            default: begin
                case (payload[1:0])
                    SYS_POP: begin need = 2'd1; pop = 2'd1; end
                    SYS_DUP: begin need = 2'd1; push = 1'b1; wdata = top; end
                    SYS_HALT: halt = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

    // Core sequencer; a stack error commits nothing and parks the core in FAULT.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_FETCH;
            ip_q     <= '0;
            instr_q  <= '0;
            carry_q  <= 1'b0;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem.i_imemAck) begin
                        instr_q <= imem.i_instr;
                        req_q   <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (st_err) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end else if (halt) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        ip_q    <= ip_d;
                        carry_q <= carry_d;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem.o_imemAddr = ip_q;
    assign imem.o_imemReq  = req_q;
    assign o_top           = top;
    assign o_carry         = carry_q;
    assign o_halted        = halted_q;
    assign o_fault         = fault_q;
endmodule

// File: tb/tb_stack_cpu_core.sv
// Bench for stack_cpu_core: a wait-state memory model serves programs, a
// scoreboard queue holds the expected architectural state after each
// instruction, and a monitor compares whenever the core starts a new fetch
// or enters HALT/FAULT.
module tb_stack_cpu_core;
    localparam int DW = 16, AW = 16, SD = 4, DPW = $clog2(SD) + 1;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    stack_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    logic [DW-1:0]  top;
    logic [DPW-1:0] depth;
    logic           carry, halted, fault;

    stack_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .imem    (bus),
        .o_top   (top),
        .o_depth (depth),
        .o_carry (carry),
        .o_halted(halted),
        .o_fault (fault)
    );

    typedef struct {
        string          name;
        logic [DW-1:0]  top;
        logic [DPW-1:0] depth;
        logic           carry;
        logic [AW-1:0]  addr;
        logic           halted;
        logic           fault;
    } exp_t;

    exp_t          q[$];
    int            checks = 0, errors = 0;
    logic [DW+1:0] mem [256];
    int            wait_n = 0;
    bit            spurious = 0;

    function automatic logic [DW+1:0] P(input logic [DW-1:0] v); return {2'b00, v}; endfunction
    function automatic logic [DW+1:0] A(input logic [2:0] op); return {2'b01, 13'd0, op}; endfunction
    function automatic logic [DW+1:0] J(input logic [2:0] c, input logic [12:0] t); return {2'b10, c, t}; endfunction
    function automatic logic [DW+1:0] S(input logic [1:0] k); return {2'b11, 14'd0, k}; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ex(input string name, input logic [DW-1:0] t, input int d, input logic c,
                      input logic [AW-1:0] a, input logic h = 1'b0, input logic f = 1'b0);
        exp_t e;
        e.name = name; e.top = t; e.depth = DPW'(d); e.carry = c;
        e.addr = a; e.halted = h; e.fault = f;
        q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = S(2'd3);
    endtask

    task automatic hold_reset();
        @(negedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d expected results still pending, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic idle_check(input string name);
        repeat (3) begin
            @(negedge clk);
            chk({name, "_no_req"}, bus.o_imemReq, 0);
        end
    endtask

    // Instruction memory with wait_n wait states; checks the request holds still.
    always @(negedge clk) begin : responder
        static int cnt = 0;
        static bit pend = 0;
        static logic [AW-1:0] held = '0;
        if (rst) begin
            bus.i_imemAck = 1'b0; bus.i_instr = '0; pend = 0;
        end else if (bus.o_imemReq) begin
            if (!pend) begin
                pend = 1; cnt = 0; held = bus.o_imemAddr;
            end else begin
                chk("addr_stable", bus.o_imemAddr, held);
            end
            if (cnt >= wait_n) begin
                bus.i_imemAck = 1'b1; bus.i_instr = mem[bus.o_imemAddr[7:0]]; pend = 0;
            end else begin
                bus.i_imemAck = 1'b0; bus.i_instr = '0; cnt++;
            end
        end else begin
            bus.i_imemAck = spurious;
            bus.i_instr   = spurious ? P(16'hDEAD) : '0;
            pend = 0;
        end
    end

    // Monitor: a new fetch or entry into HALT/FAULT presents a result.
    always @(negedge clk) begin : monitor
        static bit prev_req = 0, prev_hf = 0;
        exp_t e;
        if (rst) begin
            prev_req = 0; prev_hf = 0;
        end else begin
            if ((bus.o_imemReq && !prev_req) || ((halted || fault) && !prev_hf)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got top=%h depth=%0d addr=%h halted=%b fault=%b, required none",
                             top, depth, bus.o_imemAddr, halted, fault);
                end else begin
                    e = q.pop_front();
                    if ({top, depth, carry, bus.o_imemAddr, halted, fault} !==
                        {e.top, e.depth, e.carry, e.addr, e.halted, e.fault}) begin
                        errors++;
                        $display("FAIL %s: got top=%h depth=%0d carry=%b addr=%h halted=%b fault=%b, expected top=%h depth=%0d carry=%b addr=%h halted=%b fault=%b",
                                 e.name, top, depth, carry, bus.o_imemAddr, halted, fault,
                                 e.top, e.depth, e.carry, e.addr, e.halted, e.fault);
                    end
                end
            end
            prev_req = bus.o_imemReq;
            prev_hf  = halted || fault;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_imemAck = 1'b0; bus.i_instr = '0;
        repeat (2) @(posedge clk);

        // PUSH 5, PUSH 3, ADD with zero-wait memory, plus 6-cycle latency.
        clear_mem(); wait_n = 0;
        mem[0] = P(5); mem[1] = P(3); mem[2] = A(3'd0);
        ex("t1_reset", 0, 0, 0, 0); ex("t1_push5", 5, 1, 0, 1); ex("t1_push3", 3, 2, 0, 2);
        ex("t1_add", 8, 1, 0, 3);   ex("t1_halt", 8, 1, 0, 3, 1'b1);
        release_reset();
        repeat (6) @(posedge clk);
        #1 chk("t1_top_6cyc", top, 8); chk("t1_depth_6cyc", depth, 1); chk("t1_carry_6cyc", carry, 0);
        wait_empty("t1", 100); idle_check("t1");

        // Carry-out and conditional jumps, zero-wait then 3 wait states each fetch.
        for (int w = 0; w <= 3; w += 3) begin
            hold_reset(); clear_mem(); wait_n = w;
            mem[0] = P(16'hFFFF); mem[1] = P(1); mem[2] = A(3'd0); mem[3] = J(3'd1, 13'h20);
            mem[32] = J(3'd3, 13'h24); mem[36] = P(16'h8000); mem[37] = J(3'd4, 13'h28);
            mem[40] = J(3'd1, 13'h30);
            ex("t2_reset", 0, 0, 0, 0); ex("t2_pushffff", 16'hFFFF, 1, 0, 1); ex("t2_push1", 1, 2, 0, 2);
            ex("t2_add_wrap", 0, 1, 1, 3); ex("t2_jz_taken", 0, 1, 1, 16'h20);
            ex("t2_jc_taken", 0, 1, 1, 16'h24); ex("t2_push8000", 16'h8000, 2, 1, 16'h25);
            ex("t2_jneg_taken", 16'h8000, 2, 1, 16'h28); ex("t2_jz_not_taken", 16'h8000, 2, 1, 16'h29);
            ex("t2_halt", 16'h8000, 2, 1, 16'h29, 1'b1);
            release_reset();
            wait_empty("t2", 400); idle_check("t2");
        end

        // ALU ops, DUP/POP/NOP, spurious acks while not requesting, ending in an underflow.
        hold_reset(); clear_mem(); wait_n = 1; spurious = 1;
        mem[0] = P(6); mem[1] = P(9); mem[2] = A(3'd1); mem[3] = P(3); mem[4] = A(3'd1);
        mem[5] = P(16'h0F0F); mem[6] = A(3'd2); mem[7] = P(16'h00F0); mem[8] = A(3'd3);
        mem[9] = P(16'h0FF0); mem[10] = A(3'd4); mem[11] = A(3'd5); mem[12] = S(2'd2);
        mem[13] = A(3'd7); mem[14] = P(1); mem[15] = A(3'd6); mem[16] = S(2'd2); mem[17] = S(2'd1);
        mem[18] = S(2'd0); mem[19] = P(2); mem[20] = A(3'd1); mem[21] = S(2'd1); mem[22] = S(2'd1);
        ex("t3_reset", 0, 0, 0, 0); ex("t3_push6", 6, 1, 0, 1); ex("t3_push9", 9, 2, 0, 2);
        ex("t3_sub_borrow", 16'hFFFD, 1, 0, 3); ex("t3_push3", 3, 2, 0, 4);
        ex("t3_sub_noborrow", 16'hFFFA, 1, 1, 5); ex("t3_push0f0f", 16'h0F0F, 2, 1, 6);
        ex("t3_and", 16'h0F0A, 1, 1, 7); ex("t3_push00f0", 16'h00F0, 2, 1, 8);
        ex("t3_or", 16'h0FFA, 1, 1, 9); ex("t3_push0ff0", 16'h0FF0, 2, 1, 10);
        ex("t3_xor", 16'h000A, 1, 1, 11); ex("t3_not", 16'hFFF5, 1, 1, 12);
        ex("t3_dup", 16'hFFF5, 2, 1, 13); ex("t3_shl", 16'hFFEA, 1, 1, 14);
        ex("t3_push1", 1, 2, 1, 15); ex("t3_adc", 16'hFFEC, 1, 0, 16);
        ex("t3_dup2", 16'hFFEC, 2, 0, 17); ex("t3_pop", 16'hFFEC, 1, 0, 18);
        ex("t3_nop", 16'hFFEC, 1, 0, 19); ex("t3_push2", 2, 2, 0, 20);
        ex("t3_sub2", 16'hFFEA, 1, 1, 21); ex("t3_pop_last", 0, 0, 1, 22);
        ex("t3_pop_underflow", 0, 0, 1, 22, 1'b0, 1'b1);
        release_reset();
        wait_empty("t3", 400); idle_check("t3");
        spurious = 0;

        // Overflow: fifth push into a 4-deep stack faults with the stack untouched.
        hold_reset(); clear_mem(); wait_n = 2;
        for (int i = 0; i < 5; i++) mem[i] = P(DW'(i + 1));
        ex("t4_reset", 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) ex($sformatf("t4_push%0d", i), DW'(i), i, 0, AW'(i));
        ex("t4_overflow", 4, 4, 0, 4, 1'b0, 1'b1);
        release_reset();
        wait_empty("t4", 200); idle_check("t4");

        // HALT at address 7 is absorbing; a reset pulse restarts at 0.
        hold_reset(); clear_mem(); wait_n = 0;
        for (int i = 0; i < 7; i++) mem[i] = S(2'd0);
        ex("t5_reset", 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) ex($sformatf("t5_nop%0d", i), 0, 0, 0, AW'(i));
        ex("t5_halt", 0, 0, 0, 7, 1'b1);
        release_reset();
        wait_empty("t5", 200); idle_check("t5");
        chk("t5_addr_held", bus.o_imemAddr, 7);
        hold_reset();
        ex("t5_restart", 0, 0, 0, 0);
        release_reset();
        wait_empty("t5r", 50);

        // Reset lands while a fetch is being acknowledged: the word is dropped.
        hold_reset(); clear_mem(); wait_n = 0;
        mem[0] = P(7);
        ex("t6_reset", 0, 0, 0, 0);
        release_reset();
        @(negedge clk); #2 rst = 1'b1;
        #1 chk("t6_addr_in_reset", bus.o_imemAddr, 0); chk("t6_depth_in_reset", depth, 0);
        @(posedge clk); #1 chk("t6_depth_after_edge", depth, 0); chk("t6_top_after_edge", top, 0);
        chk("t6_ip_after_edge", bus.o_imemAddr, 0);
        ex("t6_reset2", 0, 0, 0, 0); ex("t6_push7", 7, 1, 0, 1); ex("t6_halt", 7, 1, 0, 1, 1'b1);
        release_reset();
        wait_empty("t6", 100); idle_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_cpu_core.md
STACK_CPU_CORE -- requirements
Module: stack_cpu_core

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, datapath/word width; ADDR_W, default 16, instruction-address width (ADDR_W <= DATA_W); STACK_DEPTH, default 16, data-stack entries (power of two, >= 4).
REQ-002 Ports SHALL be:
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- o_imemAddr  out  ADDR_W  instruction fetch address (= IP).
- o_imemReq  out  1  fetch request.
- i_imemAck  in  1  fetch acknowledge; i_instr valid this cycle.
- i_instr  in  DATA_W+2  instruction word: [DATA_W+1:DATA_W] class, [DATA_W-1:0] payload.
- o_top  out  DATA_W  current top of stack (0 when empty).
- o_depth  out  $clog2(STACK_DEPTH)+1  occupied entries.
- o_carry  out  1  carry flag.
- o_halted  out  1  core in HALT.
- o_fault  out  1  core in FAULT.

Function
REQ-003 The FSM SHALL have four states: FETCH, EXEC, HALT, FAULT.
REQ-004 In FETCH, o_imemReq SHALL be 1 and o_imemAddr SHALL hold IP stable until the cycle where i_imemAck=1; the instruction SHALL be latched on that edge and the FSM SHALL go to EXEC.
REQ-005 EXEC SHALL last exactly one cycle and return to FETCH unless HALT or FAULT is entered; minimum rate is one instruction per 2 cycles.
REQ-006 o_imemReq SHALL be 0 in EXEC, HALT and FAULT.
REQ-007 Class 00 (PUSH) SHALL push payload; IP <= IP+1.
REQ-008 Class 01 (ALU) SHALL pop T (top) and S (next) and push result; payload[2:0] selects: 0 S+T, 1 S-T, 2 S&T, 3 S|T, 4 S^T, 5 ~T (pops only T), 6 S+T+carry, 7 T<<1.
REQ-009 ADD, SUB, ADC and SHL SHALL write carry (SUB carry = no-borrow); logic ops SHALL leave carry unchanged.
REQ-010 Arithmetic SHALL wrap modulo 2^DATA_W.
REQ-011 Class 10 (JUMP) SHALL load IP <= payload[ADDR_W-1:0] when the condition in the payload top bits [DATA_W-1:DATA_W-3] holds, else IP+1: 0 always, 1 top==0, 2 top!=0, 3 carry, 4 top MSB=1, 5-7 never; JUMP SHALL NOT pop.
REQ-012 Class 11 (SYS) SHALL decode payload[1:0]: 0 NOP, 1 POP, 2 DUP, 3 HALT.
REQ-013 IP+1 SHALL wrap from 2^ADDR_W-1 to 0.
REQ-014 A push at depth STACK_DEPTH (overflow), or a pop below depth 0 (underflow, including ALU with fewer than 2 operands, or 1 for NOT), SHALL enter FAULT with stack, carry and IP unchanged.
REQ-015 HALT and FAULT SHALL be absorbing; only i_reset exits them.
REQ-016 o_top, o_depth, o_carry SHALL update on the EXEC edge and be stable through the following FETCH.
REQ-017 i_imemAck while o_imemReq=0 SHALL be ignored.

Reset
REQ-018 i_reset=1 SHALL asynchronously force: state FETCH, IP 0, depth 0, carry 0, o_top 0, o_halted 0, o_fault 0; o_imemReq SHALL be 1 in the first cycle after release.
REQ-019 Reset asserted mid-fetch SHALL abandon the pending request; a late ack SHALL not be latched.
REQ-020 Stack storage contents need not be reset; only depth is.

Structure
REQ-021 A shared package SHALL hold class codes, ALU op codes, jump condition codes, SYS codes and the FSM state enum.
REQ-022 The data stack (storage, depth counter, overflow/underflow detection) SHALL be a sub-module named data_stack, parameterised by DATA_W and STACK_DEPTH.

Verification
REQ-023 Reset, PUSH 5, PUSH 3, ALU ADD, ack immediate -> o_top=8, o_depth=1, o_carry=0 after 6 cycles.
REQ-024 PUSH 0xFFFF, PUSH 1, ADD (DATA_W=16) -> o_top=0, o_carry=1; then JUMP cond 1 to 0x20 -> o_imemAddr=0x20.
REQ-025 Ack delayed 3 cycles per fetch -> o_imemAddr and o_imemReq stable throughout; results identical to zero-wait run.
REQ-026 STACK_DEPTH=4: five PUSHes -> o_fault=1 after fifth EXEC, o_depth=4, o_imemReq=0 thereafter; POP on empty stack -> o_fault=1, o_depth=0.
REQ-027 SYS HALT at address 7 -> o_halted=1, o_imemAddr=7, no further requests; i_reset pulse -> FETCH at address 0.
REQ-028 i_reset asserted while o_imemReq=1 and ack arrives same cycle -> instruction discarded, IP=0, depth=0.
